// File: rtl/uart_pkg.sv
// uart_pkg: shared types, frame-format encodings and helpers for the UART blocks
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;
  localparam int MIN_DIV = 1;
  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    return bits == DB_5 ? 8'h1F : bits == DB_6 ? 8'h3F : bits == DB_7 ? 8'h7F : 8'hFF;
  endfunction
  function automatic logic [2:0] last_bit(input logic [1:0] bits);
    return {1'b0, bits} + 3'd4;
  endfunction
  function automatic parity_e to_parity(input logic [1:0] p);
    return p == 2'b01 ? PAR_EVEN : p == 2'b10 ? PAR_ODD : PAR_NONE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with MSB-compare pointers, flush and occupancy level
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = r_wr_ptr == r_rd_ptr;
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty;
  // flush drops everything not already popped this cycle, including a same-cycle push
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      r_rd_ptr <= i_flush ? r_wr_ptr : r_rd_ptr + {{AW{1'b0}}, w_pop};
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with runtime frame format, baud divisor and TX FIFO
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rstn,
  input  logic                              i_valid,
  input  logic [7:0]                        i_data,
  output logic                              o_ready,
  input  logic                              i_flush,
  input  logic [DIV_W-1:0]                  i_div,
  input  logic [1:0]                        i_data_bits,
  input  logic [1:0]                        i_parity,
  input  logic                              i_stop2,
  output logic                              o_uart_tx,
  output logic                              o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level
);
  tx_state_e        r_state, w_nxt_state;
  logic [DIV_W-1:0] r_cnt, w_nxt_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_eff;
  logic [2:0]       r_idx, w_nxt_idx;
  logic [2:0]       r_last;
  logic [7:0]       r_shift, w_nxt_shift;
  logic             r_par;
  parity_e          r_parity;
  logic             r_stop2;
  logic             r_stop_idx, w_nxt_stop_idx;
  logic             r_tx, w_nxt_tx;
  logic             r_busy;
  logic             w_load;
  logic             w_bit_end;
  logic [7:0]       w_rdata;
  logic             w_empty;
  logic             w_full;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (i_flush),
    .i_push  (i_valid),
    .i_pop   (w_load),
    .i_wdata (i_data),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );
  assign o_ready   = !w_full;
  assign o_uart_tx = r_tx;
  assign o_busy    = r_busy;
  assign w_div_eff = (i_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_div;
  assign w_bit_end = r_cnt == r_div;
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_idx      = r_idx;
    w_nxt_shift    = r_shift;
    w_nxt_stop_idx = r_stop_idx;
    w_nxt_tx       = r_tx;
    w_load         = 1'b0;
    w_nxt_cnt      = (r_state == IDLE || w_bit_end) ? '0 : r_cnt + 1'b1;
    case (r_state)
      IDLE: w_load = !w_empty;
      START:
        if (w_bit_end) begin
          w_nxt_state = DATA;
          w_nxt_tx    = r_shift[0];
          w_nxt_shift = r_shift >> 1;
          w_nxt_idx   = '0;
        end
      DATA:
        if (w_bit_end) begin
          if (r_idx == r_last) begin
            w_nxt_state    = (r_parity == PAR_NONE) ? STOP : PARITY;
            w_nxt_tx       = (r_parity == PAR_NONE) ? 1'b1 : r_par;
            w_nxt_stop_idx = 1'b0;
          end else begin
            w_nxt_idx   = r_idx + 1'b1;
            w_nxt_tx    = r_shift[0];
            w_nxt_shift = r_shift >> 1;
          end
        end
      PARITY:
        if (w_bit_end) begin
          w_nxt_state    = STOP;
          w_nxt_tx       = 1'b1;
          w_nxt_stop_idx = 1'b0;
        end
      STOP:
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_idx) w_nxt_stop_idx = 1'b1;
          else begin
            w_nxt_state = IDLE;
            w_nxt_tx    = 1'b1;
            w_load      = !w_empty;
          end
        end
      default: w_nxt_state = IDLE;
    endcase
    // a pending byte starts its frame on the same edge, leaving no idle gap
    if (w_load) begin
      w_nxt_state = START;
      w_nxt_tx    = 1'b0;
      w_nxt_shift = w_rdata;
      w_nxt_cnt   = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div      <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_parity   <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_idx      <= w_nxt_idx;
      r_shift    <= w_nxt_shift;
      r_stop_idx <= w_nxt_stop_idx;
      r_tx       <= w_nxt_tx;
      r_busy     <= (r_state != IDLE) || !w_empty;
      if (w_load) begin
        r_div    <= w_div_eff;
        r_last   <= last_bit(i_data_bits);
        r_parity <= to_parity(i_parity);
        r_par    <= ^(w_rdata & data_mask(i_data_bits)) ^ (to_parity(i_parity) == PAR_ODD);
        r_stop2  <= i_stop2;
      end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed and random stimulus checked per cycle against a frame-level model
module tb_uart_tx_cfg;
  localparam int DEPTH = 4;
  localparam int DIV_W = 16;
  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             valid = 1'b0;
  logic             flush = 1'b0;
  logic             stop2 = 1'b0;
  logic [7:0]       data = '0;
  logic [DIV_W-1:0] div = 16'd3;
  logic [1:0]       dbits = 2'd3;
  logic [1:0]       par = 2'd0;
  logic             ready, tx, busy;
  logic [2:0]       level;
  int               n_cmp = 0;
  int               n_err = 0;
  bit               chk_en = 0;
  logic [7:0]       q[$];
  bit               act = 0;
  int               t, per, nb, sz;
  bit               fb[12];
  bit               prev_b = 0;
  int               max_lvl = 0;
  bit               saw_full = 0;
  always #5 clk = ~clk;
  uart_tx_cfg #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_valid      (valid),
    .i_data       (data),
    .o_ready      (ready),
    .i_flush      (flush),
    .i_div        (div),
    .i_data_bits  (dbits),
    .i_parity     (par),
    .i_stop2      (stop2),
    .o_uart_tx    (tx),
    .o_busy       (busy),
    .o_fifo_level (level)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic start_frame(input logic [7:0] b);
    int n;
    bit x;
    x = 0;
    n = 5 + int'(dbits);
    per = (div < 2) ? 2 : int'(div) + 1;
    fb[0] = 0;
    for (int i = 0; i < n; i++) begin
      fb[1+i] = b[i];
      x ^= b[i];
    end
    nb = n + 1;
    if (par == 2'b01) begin fb[nb] = x; nb++; end
    else if (par == 2'b10) begin fb[nb] = !x; nb++; end
    fb[nb] = 1; nb++;
    if (stop2) begin fb[nb] = 1; nb++; end
    act = 1;
    t = 0;
  endtask
  always @(posedge clk) begin
    if (!rstn) begin
      q.delete();
      act = 0;
      t = 0;
      prev_b = 0;
    end else begin
      sz = q.size();
      if (act) begin
        t++;
        if (t == nb * per) act = 0;
      end
      if (!act && sz > 0) start_frame(q.pop_front());
      if (flush) q.delete();
      else if (valid && sz < DEPTH) q.push_back(data);
    end
  end
  always @(negedge clk)
    if (rstn && chk_en) begin
      check("tx", tx, act ? fb[t/per] : 1'b1);
      check("level", level, q.size());
      check("ready", ready, q.size() < DEPTH);
      if (prev_b == (act || q.size() > 0)) check("busy", busy, prev_b);
      prev_b = act || q.size() > 0;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (!ready) saw_full = 1;
    end
  task automatic cfg(input int d, input int b, input int p, input bit s);
    div = DIV_W'(d);
    dbits = 2'(b);
    par = 2'(p);
    stop2 = s;
  endtask
  task automatic push(input logic [7:0] b);
    bit ok;
    ok = 0;
    data = b;
    valid = 1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      ok = ready;
      @(negedge clk);
    end
    valid = 0;
    if (!ok) check("push_timeout", 0, 1);
  endtask
  task automatic drain();
    for (int i = 0; i < 5000 && (act || q.size() > 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_tx", tx, 1);
  endtask
  initial begin
    #2 rstn = 0;
    #10;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_ready", ready, 1);
    @(negedge clk) rstn = 1;
    chk_en = 1;
    cfg(3, 3, 0, 0); push(8'hA5); drain();
    cfg(1, 2, 1, 1); push(8'h41); drain();
    for (int d = 0; d < 2; d++) begin
      cfg(d, 0, 2, 0); push(8'hFF); drain();
      cfg(d, 0, 1, 0); push(8'hFF); drain();
    end
    cfg(7, 3, 0, 0);
    max_lvl = 0;
    saw_full = 0;
    for (int k = 0; k < 10; k++) push(8'(k));
    drain();
    check("max_level_ok", max_lvl <= DEPTH, 1);
    check("saw_not_ready", saw_full, 1);
    cfg(3, 3, 0, 0); push(8'h3C); push(8'hC3);
    repeat (10) @(negedge clk);
    cfg(9, 3, 2, 0);
    drain();
    cfg(3, 3, 0, 0); push(8'h5A);
    repeat (18) @(negedge clk);
    #2 rstn = 0;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    check("arst_level", level, 0);
    check("arst_ready", ready, 1);
    @(negedge clk);
    @(negedge clk) rstn = 1;
    repeat (60) @(negedge clk);
    check("post_rst_tx", tx, 1);
    for (int k = 0; k < 4; k++) push(8'h11 + 8'(k));
    check("pre_flush_level", level, 3);
    flush = 1; valid = 1; data = 8'hEE;
    @(negedge clk);
    flush = 0; valid = 0;
    check("flush_level", level, 0);
    drain();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      valid = 1'($urandom_range(0, 1));
      data = 8'($urandom);
      flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 99) == 0)
        cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    valid = 0;
    flush = 0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter with an integrated transmit FIFO. Successor to the fixed 8N1 transmitter in the MMIO UART.
- Frame format is programmable: data bits 5-8, parity none/even/odd, 1 or 2 stop bits.
- Baud divisor is a runtime input.
- Byte intake uses a valid/ready handshake into a FIFO, so the CPU-side MMIO wrapper can queue bytes without polling per byte.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; power of 2, >= 2
DIV_W, 16, width of the baud divisor input

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_valid  in  1  byte offered for transmission
i_data  in  8  byte to send, LSB first; bits above the active data width are ignored
o_ready  out  1  FIFO can accept; high when FIFO is not full
i_flush  in  1  synchronous FIFO clear
i_div  in  DIV_W  clocks per bit minus 1; values 0 and 1 are treated as 1 (minimum 2 clocks/bit)
i_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
i_parity  in  2  00=none, 01=even, 10=odd, 11=none
i_stop2  in  1  0=one stop bit, 1=two stop bits
o_uart_tx  out  1  serial line, idle high
o_busy  out  1  high when state != IDLE or FIFO is not empty
o_fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (asynchronous): o_uart_tx=1, o_busy=0, o_fifo_level=0, o_ready=1, state=IDLE, all counters 0, FIFO emptied. Reset asserted mid-frame aborts the frame and drives the line high immediately.
- Push: byte accepted at a rising edge when i_valid && o_ready. o_ready depends only on full, so a simultaneous pop does not admit a push while full.
- FIFO is show-ahead: head data is visible combinationally to the FSM.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Config capture: i_div, i_data_bits, i_parity and i_stop2 are latched on each frame start. Changing them mid-frame does not affect the frame in progress.
- IDLE: if the FIFO is non-empty, pop at this edge, latch byte and config, set o_uart_tx<=0, go to START.
- Latency: a byte pushed at edge N into an empty FIFO while IDLE produces the start bit low from edge N+1.
- Bit timing: each bit lasts div_eff+1 clocks, where div_eff = max(latched div, 1). The bit counter is DIV_W wide and resets to 0 at each bit boundary.
- START -> DATA: LSB first, nbits = 5 + i_data_bits.
- DATA -> PARITY if parity is enabled, else -> STOP.
- Parity bit:
  - even: XOR of the nbits data bits sent.
  - odd: inverse of that XOR.
  - Unused upper data bits never contribute.
- STOP: line high for 1 or 2 bit times.
- End of last stop bit:
  - FIFO non-empty: pop, drive start bit on the same edge, no idle gap.
  - FIFO empty: go to IDLE.
- o_busy is registered and follows its definition with one cycle of lag at most; it must be 0 one cycle after return to IDLE with the FIFO empty.
- Flush: i_flush empties the FIFO at the next edge. The frame currently on the line completes normally.
- Flush and push in the same cycle: flush wins and the pushed byte is dropped.
- Flush and pop in the same cycle: the pop proceeds, and the popped byte is transmitted.
- Pointer wrap-around: FIFO pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty are decided by the MSB compare.
- Level arithmetic: simultaneous push and pop leaves level unchanged. Level never exceeds FIFO_DEPTH.

Decomposition:
- Package uart_pkg:
  - parity_e (NONE, EVEN, ODD)
  - tx_state_e (IDLE, START, DATA, PARITY, STOP)
  - data_bits encoding constants
  - MIN_DIV = 1
- Sub-module sync_fifo #(WIDTH=8, DEPTH=FIFO_DEPTH):
  - ports: clock, async reset, flush, push/pop, show-ahead rdata, full, empty, level.
  - Reused later by the UART RX path.

Test Plan:
1. i_div=3, 8N1, push 0xA5 at edge N -> line low edges N+1..N+4, then data bits 1,0,1,0,0,1,0,1 each 4 clocks, then high 4 clocks. 40-clock frame; o_busy drops within 1 cycle after the frame.
2. i_div=1, 7 bits, even parity, 2 stop bits, push 0x41 -> data 1,0,0,0,0,0,1, parity 0, then 2 stop bits. 11 bits x 2 clocks = 22 clocks; bit 7 of the byte is never sent.
3. 5 bits, push 0xFF: odd parity -> parity bit 0; even parity -> parity bit 1. i_div=0 behaves identically to i_div=1.
4. FIFO_DEPTH=4, i_div=7, offer 10 bytes 0x00..0x09 with i_valid held:
   - o_ready deasserts while full.
   - o_fifo_level never exceeds 4.
   - All 10 bytes appear in order.
   - Each stop bit is immediately followed by the next start bit.
5. Change i_div 3->9 and i_parity none->odd mid-frame -> current frame keeps 4 clocks/bit with no parity bit; next frame uses 10 clocks/bit plus a parity bit.
6. Two cases:
   - Assert i_rstn low during data bit 3 -> o_uart_tx=1 immediately, o_busy=0, level 0, no residual frame after release.
   - Separately, i_flush together with i_valid while 3 bytes are queued -> current frame completes, queued and new bytes are dropped, level 0.
